// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - state encoding, access-size codes and byte-count helper for mem_ctrl
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IF_RD = 3'd1,
    LS_RD = 3'd2,
    LS_WR = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [1:0] SIZE_BYTE     = 2'd0;
  localparam logic [1:0] SIZE_HALF     = 2'd1;
  localparam logic [1:0] SIZE_WORD     = 2'd2;
  localparam logic [1:0] SIZE_WORD_ALT = 2'd3;

  localparam logic [2:0] FETCH_BYTES = 3'd4;

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SIZE_BYTE:     return 3'd1;
      SIZE_HALF:     return 3'd2;
      SIZE_WORD:     return 3'd4;
      SIZE_WORD_ALT: return 3'd4;
      default:       return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial arbiter between instruction fetch and load/store over a byte-wide RAM
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ack,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_ack,
  output logic [31:0]       ls_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  state_e            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        next_k;
  logic [1:0]        rd_lane, wr_lane;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;
  logic              if_ack_q, if_ack_d;
  logic              ls_ack_q, ls_ack_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       ls_rdata_q, ls_rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [7:0]        ram_dout_q, ram_dout_d;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    n_d        = n_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    if_ack_d   = 1'b0;
    ls_ack_d   = 1'b0;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    ram_addr_d = '0;
    ram_we_d   = 1'b0;
    ram_dout_d = 8'h00;
    next_k     = k_q + 3'd1;
    rd_lane    = 2'(k_q - 3'd1);
    wr_lane    = next_k[1:0];

    case (state_q)
      IDLE: begin
        // Load/store wins; a flush only vetoes the fetch side.
        if (ls_req) begin
          addr_d     = ls_addr;
          n_d        = byte_count(ls_size);
          wdata_d    = ls_wdata;
          asm_d      = '0;
          k_d        = '0;
          ram_addr_d = ls_addr;
          if (ls_we) begin
            state_d    = LS_WR;
            ram_we_d   = 1'b1;
            ram_dout_d = ls_wdata[7:0];
          end else begin
            state_d = LS_RD;
          end
        end else if (if_req && !if_flush) begin
          addr_d     = if_addr;
          n_d        = FETCH_BYTES;
          asm_d      = '0;
          k_d        = '0;
          ram_addr_d = if_addr;
          state_d    = IF_RD;
        end
      end

      IF_RD, LS_RD: begin
        // ram_din lags the address by one cycle, so cycle k returns byte k-1.
        if (k_q != 3'd0) begin
          asm_d[{rd_lane, 3'b000} +: 8] = ram_din;
        end
        if (state_q == IF_RD && if_flush) begin
          state_d = IDLE;
          k_d     = '0;
        end else if (k_q == n_q) begin
          state_d = DONE;
          k_d     = '0;
          if (state_q == IF_RD) begin
            if_ack_d  = 1'b1;
            if_data_d = asm_d;
          end else begin
            ls_ack_d   = 1'b1;
            ls_rdata_d = asm_d;
          end
        end else begin
          k_d = next_k;
          if (next_k < n_q) begin
            ram_addr_d = addr_q + ADDR_W'(next_k);
          end
        end
      end

      LS_WR: begin
        if (next_k < n_q) begin
          k_d        = next_k;
          ram_addr_d = addr_q + ADDR_W'(next_k);
          ram_we_d   = 1'b1;
          ram_dout_d = wdata_q[{wr_lane, 3'b000} +: 8];
        end else begin
          state_d  = DONE;
          k_d      = '0;
          ls_ack_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      n_q        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      asm_q      <= '0;
      if_ack_q   <= 1'b0;
      ls_ack_q   <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      ram_dout_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      asm_q      <= asm_d;
      if_ack_q   <= if_ack_d;
      ls_ack_q   <= ls_ack_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
      ram_addr_q <= ram_addr_d;
      ram_we_q   <= ram_we_d;
      ram_dout_q <= ram_dout_d;
    end
  end

  // A flush arriving in the ack cycle still suppresses the fetch ack.
  assign if_ack   = if_ack_q & ~if_flush;
  assign if_data  = if_data_q;
  assign ls_ack   = ls_ack_q;
  assign ls_rdata = ls_rdata_q;
  assign ram_addr = ram_addr_q;
  assign ram_we   = ram_we_q;
  assign ram_dout = ram_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl with byte-RAM model and reference model
module tb_mem_ctrl;

  localparam int K_IF = 0;
  localparam int K_LD = 1;
  localparam int K_ST = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_ack;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_we, ls_ack;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_dout, ram_din;
  logic        mem_clr;

  int checks;
  int failures;

  logic [7:0] ram [0:4095];
  logic [7:0] ref_mem [0:4095];

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  // Synchronous byte RAM, read data one cycle after its address; 4 KiB aliased.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
    end else if (ram_we) begin
      ram[ram_addr[11:0]] <= ram_dout;
    end
    ram_din <= ram[ram_addr[11:0]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int ref_n(input int kind, input logic [1:0] size);
    if (kind == K_IF) return 4;
    if (size == 2'd0) return 1;
    if (size == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] addr, input int n);
    logic [31:0] r;
    logic [31:0] a;
    r = '0;
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      r[8*k +: 8] = ref_mem[a[11:0]];
    end
    return r;
  endfunction

  task automatic ref_write(input logic [31:0] addr, input logic [31:0] wdata, input int n);
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      ref_mem[a[11:0]] = wdata[8*k +: 8];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request in the current cycle (T) and checks the RAM bus each cycle until the ack.
  task automatic run_txn(input int kind, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] data, output int lat);
    int          n;
    logic        act;
    logic        ack;
    logic [31:0] exp_addr;
    logic [31:0] sh;
    n    = ref_n(kind, size);
    lat  = -1;
    data = '0;
    if (kind == K_IF) begin
      if_req  = 1'b1;
      if_addr = addr;
    end else begin
      ls_req   = 1'b1;
      ls_we    = (kind == K_ST);
      ls_size  = size;
      ls_addr  = addr;
      ls_wdata = wdata;
    end
    for (int c = 1; c <= 12 && lat < 0; c++) begin
      step();
      act      = (c <= n);
      exp_addr = act ? addr + 32'(c - 1) : 32'h0;
      sh       = wdata >> (8 * (c - 1));
      chk($sformatf("ram_addr_c%0d", c), ram_addr, exp_addr);
      chk($sformatf("ram_we_c%0d", c), ram_we, act && kind == K_ST);
      chk($sformatf("ram_dout_c%0d", c), ram_dout, (act && kind == K_ST) ? sh[7:0] : 8'h00);
      chk($sformatf("other_ack_c%0d", c), (kind == K_IF) ? ls_ack : if_ack, 1'b0);
      ack = (kind == K_IF) ? if_ack : ls_ack;
      if (ack) begin
        lat  = c;
        data = (kind == K_IF) ? if_data : ls_rdata;
      end
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    ls_we  = 1'b0;
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout actual=none required=ack kind=%0d addr=0x%0h", kind, addr);
    end
    step();
  endtask

  typedef struct {
    int          kind;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, got2, wd, ad;
    logic [1:0]  sz;
    int          lat, lat2, kind, ls_lat, if_start, if_lat, n;
    logic        saw;

    checks   = 0;
    failures = 0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    rst = 1'b1; mem_clr = 1'b1;
    if_req = 0; if_addr = 0; if_flush = 0;
    ls_req = 0; ls_we = 0; ls_size = 0; ls_addr = 0; ls_wdata = 0;
    repeat (3) step();
    mem_clr = 1'b0;
    chk("rst_if_ack", if_ack, 0);
    chk("rst_ls_ack", ls_ack, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_dout", ram_dout, 0);
    rst = 1'b0;
    step();

    vecs[0]  = '{K_ST, 2'd2, 32'h0000_0100, 32'h0010_0513, 32'h0,         5};
    vecs[1]  = '{K_IF, 2'd0, 32'h0000_0100, 32'h0,         32'h0010_0513, 6};
    vecs[2]  = '{K_ST, 2'd1, 32'h0000_0202, 32'hAABB_CCDD, 32'h0,         3};
    vecs[3]  = '{K_LD, 2'd1, 32'h0000_0202, 32'h0,         32'h0000_CCDD, 4};
    vecs[4]  = '{K_LD, 2'd0, 32'h0000_0203, 32'h0,         32'h0000_00CC, 3};
    vecs[5]  = '{K_LD, 2'd2, 32'h0000_0101, 32'h0,         32'h0000_1005, 6};
    vecs[6]  = '{K_LD, 2'd3, 32'h0000_0100, 32'h0,         32'h0010_0513, 6};
    vecs[7]  = '{K_ST, 2'd0, 32'h0000_0010, 32'h1234_5680, 32'h0,         2};
    vecs[8]  = '{K_LD, 2'd0, 32'h0000_0010, 32'h0,         32'h0000_0080, 3};
    vecs[9]  = '{K_IF, 2'd0, 32'h0000_0200, 32'h0,         32'hCCDD_0000, 6};
    vecs[10] = '{K_IF, 2'd0, 32'hFFFF_FFFE, 32'h0,         32'h0000_0000, 6};

    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i].kind, vecs[i].size, vecs[i].addr, vecs[i].wdata, got, lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      if (vecs[i].kind == K_ST)
        ref_write(vecs[i].addr, vecs[i].wdata, ref_n(K_ST, vecs[i].size));
      else
        chk($sformatf("vec%0d_data", i), got, vecs[i].exp_data);
    end

    // Simultaneous requests: load first, fetch accepted right after its DONE cycle.
    if_req = 1; if_addr = 32'h100;
    ls_req = 1; ls_we = 0; ls_size = 2'd0; ls_addr = 32'h10;
    ls_lat = -1; if_start = -1; if_lat = -1; got = '0; got2 = '0;
    for (int c = 1; c <= 16 && if_lat < 0; c++) begin
      step();
      if (ls_ack && ls_lat < 0) begin ls_lat = c; got = ls_rdata; ls_req = 0; end
      if (ram_addr == 32'h100 && if_start < 0) if_start = c;
      if (if_ack) begin if_lat = c; got2 = if_data; if_req = 0; end
    end
    if_req = 0; ls_req = 0;
    step();
    chk("both_ls_ack_cycle", ls_lat, 3);
    chk("both_ls_rdata", got, 32'h0000_0080);
    chk("both_if_first_addr_cycle", if_start, 5);
    chk("both_if_ack_cycle", if_lat, 10);
    chk("both_if_data", got2, 32'h0010_0513);

    // Flush in T+2 of a fetch: back to IDLE at T+3, no ack, no writes.
    if_req = 1; if_addr = 32'h100; saw = 0;
    step(); saw |= if_ack; chk("flush_we_t1", ram_we, 0);
    step(); saw |= if_ack; if_flush = 1; if_req = 0;
    step(); saw |= if_ack; if_flush = 0;
    chk("flush_ram_addr_t3", ram_addr, 0);
    chk("flush_we_t3", ram_we, 0);
    run_txn(K_LD, 2'd0, 32'h100, 32'h0, got, lat);
    chk("flush_idle_accept_lat", lat, 3);
    chk("flush_idle_accept_data", got, 32'h13);
    chk("flush_no_if_ack", saw, 0);

    // Flush coinciding with the fetch DONE cycle hides the ack.
    if_req = 1; if_addr = 32'h100;
    repeat (6) step();
    if_flush = 1; #1;
    chk("flush_gates_if_ack", if_ack, 0);
    if_flush = 0; if_req = 0;
    step();
    chk("after_done_ram_addr", ram_addr, 0);

    // Flush in IDLE blocks the fetch for that cycle only, but not load/store.
    if_req = 1; if_addr = 32'h200; if_flush = 1;
    step();
    chk("idle_flush_blocks", ram_addr, 0);
    if_flush = 0;
    run_txn(K_IF, 2'd0, 32'h200, 32'h0, got, lat);
    chk("idle_flush_later_lat", lat, 6);
    chk("idle_flush_later_data", got, 32'hCCDD_0000);
    if_flush = 1;
    run_txn(K_LD, 2'd1, 32'h202, 32'h0, got, lat);
    if_flush = 0;
    chk("flush_ls_lat", lat, 4);
    chk("flush_ls_data", got, 32'h0000_CCDD);

    // Reset in T+2 of a 4-byte store: bytes 0-1 land, nothing else.
    ls_req = 1; ls_we = 1; ls_size = 2'd2; ls_addr = 32'h500; ls_wdata = 32'h4433_2211; saw = 0;
    step(); saw |= ls_ack;
    step(); saw |= ls_ack; rst = 1; ls_req = 0; ls_we = 0;
    step(); saw |= ls_ack;
    chk("mid_rst_if_ack", if_ack, 0);
    chk("mid_rst_ls_ack", ls_ack, 0);
    chk("mid_rst_if_data", if_data, 0);
    chk("mid_rst_ls_rdata", ls_rdata, 0);
    chk("mid_rst_ram_addr", ram_addr, 0);
    chk("mid_rst_ram_we", ram_we, 0);
    chk("mid_rst_ram_dout", ram_dout, 0);
    rst = 0;
    ref_write(32'h500, 32'h0000_2211, 2);
    step(); saw |= ls_ack;
    chk("mid_rst_no_ls_ack", saw, 0);
    run_txn(K_LD, 2'd2, 32'h500, 32'h0, got, lat);
    chk("mid_rst_partial_bytes", got, 32'h0000_2211);

    // Random traffic against the reference memory.
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      sz   = 2'($urandom_range(0, 3));
      wd   = $urandom;
      if ($urandom_range(0, 7) == 0) ad = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else                           ad = 32'h600 + 32'($urandom_range(0, 31));
      n = ref_n(kind, sz);
      run_txn(kind, sz, ad, wd, got, lat);
      if (kind == K_ST) begin
        chk($sformatf("rnd%0d_latency", i), lat, n + 1);
        ref_write(ad, wd, n);
      end else begin
        chk($sformatf("rnd%0d_latency", i), lat, n + 2);
        chk($sformatf("rnd%0d_data", i), got, ref_read(ad, n));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
